// File: rtl/parity_check_arbiter_pkg.sv
// rtl/parity_check_arbiter_pkg.sv - shared constants and FSM encoding for the parity check arbiter
//
// Purpose: state encoding and datapath width used by the arbiter, its
//          interface and its checker.
// Ports:   none (package).
package parity_check_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/parity_check_arbiter_if.sv
// rtl/parity_check_arbiter_if.sv - request/response bundle between requesters, arbiter and consumer
//
// Purpose: groups the N request channels and the single response channel.
// Ports (signals):
//   req_valid/req_ready [N]      per-requester handshake
//   req_data [DATA_W*N]          byte of requester i at [8i+7:8i]
//   req_parity/req_odd [N]       received parity bit and mode (0 even, 1 odd)
//   rsp_valid/rsp_ready          response handshake
//   rsp_id/rsp_data/rsp_error    owner, echoed byte and check result
// Modports: master = requesters + consumer side, slave = arbiter side.
interface parity_check_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
);
  import parity_check_arbiter_pkg::*;

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [DATA_W*N-1:0] req_data;
  logic [N-1:0]        req_parity;
  logic [N-1:0]        req_odd;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_error;

  modport master (
    output req_valid, req_data, req_parity, req_odd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_data, req_parity, req_odd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_error
  );

endinterface

// File: rtl/parity_check_arbiter_checker.sv
// rtl/parity_check_arbiter_checker.sv - combinational 8-bit parity checker
//
// Purpose: flags a parity mismatch for the selected mode.
// Ports:
//   data       in  [8]  byte under check
//   parity_bit in       received parity bit
//   even_odd   in       0 = even, 1 = odd
//   error      out      1 = mismatch
module parity_checker
  import parity_check_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic              parity_bit,
  input  logic              even_odd,
  output logic              error
);

  // Even: error when XOR(data) != parity. Odd: error when they are equal,
  // which is the even result inverted.
  assign error = (^data) ^ parity_bit ^ even_odd;

endmodule

// File: rtl/parity_check_arbiter.sv
// rtl/parity_check_arbiter.sv - round-robin arbiter sharing one parity checker among N requesters
//
// Purpose: grants one requester at a time, registers its operands, runs the
//          shared checker and returns the result with the requester ID.
// Ports:
//   clk        in        rising-edge clock
//   rst_n      in        asynchronous active-low reset
//   bus        slave     request channels and response channel
//   clr_count  in        synchronous clear of err_count (wins over increment)
//   err_count  out [CNT_W] saturating count of errored responses delivered
module parity_check_arbiter
  import parity_check_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int ID_W  = $clog2(N),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity_check_arbiter_if.slave bus,
  input  logic                  clr_count,
  output logic [CNT_W-1:0]      err_count
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, id_q, rsp_id_q, grant_idx;
  logic              grant_found, accept, rsp_hs;
  logic [DATA_W-1:0] sel_data, op_data_q, rsp_data_q;
  logic              sel_parity, sel_odd, op_parity_q, op_odd_q;
  logic              chk_error, rsp_error_q;
  logic [CNT_W-1:0]  err_count_q;

  // Returns {found, index}. Scanning from the farthest candidate back to the
  // nearest lets the nearest valid requester after last overwrite the result.
  function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] valid,
                                            input logic [ID_W-1:0] last);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] cand;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      cand = ID_W'((int'(last) + k) % N);
      if (valid[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  always_comb begin
    {grant_found, grant_idx} = rr_pick(bus.req_valid, last_grant_q);
  end

  always_comb begin
    sel_data   = '0;
    sel_parity = 1'b0;
    sel_odd    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_data   = bus.req_data[DATA_W*i +: DATA_W];
        sel_parity = bus.req_parity[i];
        sel_odd    = bus.req_odd[i];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found;
  assign rsp_hs = (state_q == RESP) && bus.rsp_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = CHECK;
      CHECK:   state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE:    if (grant_found) bus.req_ready[grant_idx] = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  parity_checker u_checker (
    .data       (op_data_q),
    .parity_bit (op_parity_q),
    .even_odd   (op_odd_q),
    .error      (chk_error)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= ID_W'(N - 1);
      id_q         <= '0;
      op_data_q    <= '0;
      op_parity_q  <= 1'b0;
      op_odd_q     <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_data_q    <= sel_data;
        op_parity_q  <= sel_parity;
        op_odd_q     <= sel_odd;
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (state_q == CHECK) begin
        rsp_id_q    <= id_q;
        rsp_data_q  <= op_data_q;
        rsp_error_q <= chk_error;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (clr_count) begin
      err_count_q <= '0;
    end else if (rsp_hs && rsp_error_q && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_q <= err_count_q + CNT_W'(1);
    end
  end

  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// tb/tb_parity_check_arbiter.sv - directed self-checking bench for parity_check_arbiter
module tb_parity_check_arbiter;
  import parity_check_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_count = 1'b0;
  logic [CNT_W-1:0] err_count;

  int total = 0;
  int bad   = 0;

  parity_check_arbiter_if #(.N(N), .ID_W(ID_W)) bus ();

  parity_check_arbiter #(.N(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [7:0] d, input logic p, input logic o);
    bus.req_data[8*idx +: 8] = d;
    bus.req_parity[idx]      = p;
    bus.req_odd[idx]         = o;
  endtask

  // Single-requester transaction with rsp_ready high; called from IDLE.
  task automatic run_txn(input int idx, input logic [7:0] d, input logic p, input logic o,
                         output logic [ID_W-1:0] id, output logic [7:0] data, output logic err);
    set_req(idx, d, p, o);
    bus.req_valid      = '0;
    bus.req_valid[idx] = 1'b1;
    bus.rsp_ready      = 1'b1;
    #1;
    chk("txn_ready", bus.req_ready, 32'(1 << idx));
    tick();
    bus.req_valid = '0;
    chk("txn_check_no_valid", bus.rsp_valid, 0);
    tick();
    chk("txn_rsp_valid", bus.rsp_valid, 1);
    id   = bus.rsp_id;
    data = bus.rsp_data;
    err  = bus.rsp_error;
    tick();
  endtask

  logic [ID_W-1:0] r_id;
  logic [7:0]      r_data;
  logic            r_err;
  int              exp_cnt;
  int              rr_order[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  logic [7:0]      dtab[4]     = '{8'h00, 8'h03, 8'h07, 8'h0F};

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_parity = '0;
    bus.req_odd    = '0;
    bus.rsp_ready  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    tick();

    // single request, requester 2, latency
    set_req(2, 8'h5A, 1'b0, 1'b0);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t1_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    chk("t1_check_valid", bus.rsp_valid, 0);
    chk("t1_check_ready", bus.req_ready, 0);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_id", bus.rsp_id, 2);
    chk("t1_rsp_data", bus.rsp_data, 8'h5A);
    chk("t1_rsp_error", bus.rsp_error, 0);
    chk("t1_cnt_in_resp", err_count, 0);
    tick();
    chk("t1_valid_drop", bus.rsp_valid, 0);
    chk("t1_err_count", err_count, 0);

    // odd mode: 0x01 has one set bit, so parity 1 is a mismatch, parity 0 is clean
    run_txn(0, 8'h01, 1'b1, 1'b1, r_id, r_data, r_err);
    chk("t2_err_id", r_id, 0);
    chk("t2_err_flag", r_err, 1);
    chk("t2_err_count", err_count, 1);
    run_txn(0, 8'h01, 1'b0, 1'b1, r_id, r_data, r_err);
    chk("t2_ok_flag", r_err, 0);
    chk("t2_ok_count", err_count, 1);

    // round robin with all four valid; last grant is 0
    for (int i = 0; i < 4; i++) set_req(i, dtab[i], (i == 2), 1'b0);
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t3_onehot_ready", bus.req_ready, 32'(1 << rr_order[k]));
      tick();
      tick();
      chk("t3_rsp_id", bus.rsp_id, rr_order[k]);
      chk("t3_rsp_data", bus.rsp_data, dtab[rr_order[k]]);
      chk("t3_rsp_error", bus.rsp_error, 0);
      tick();
    end
    bus.req_valid = '0;

    // backpressure: 0xA5 has even weight, parity 1 in even mode is an error
    set_req(3, 8'hA5, 1'b1, 1'b0);
    set_req(1, 8'h03, 1'b0, 1'b0);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b0;
    #1;
    chk("t4_ready", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0010;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_valid", bus.rsp_valid, 1);
      chk("t4_hold_id", bus.rsp_id, 3);
      chk("t4_hold_data", bus.rsp_data, 8'hA5);
      chk("t4_hold_error", bus.rsp_error, 1);
      chk("t4_hold_no_grant", bus.req_ready, 0);
      chk("t4_hold_count", err_count, 1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_ready_indep", bus.req_ready, 0);
    tick();
    chk("t4_valid_drop", bus.rsp_valid, 0);
    chk("t4_err_count", err_count, 2);
    chk("t4_next_grant", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    #1;
    chk("t4_withdraw", bus.req_ready, 0);

    // saturation of the 4-bit counter at 15
    exp_cnt = 2;
    for (int k = 0; k < 14; k++) begin
      run_txn(0, 8'hA5, 1'b1, 1'b0, r_id, r_data, r_err);
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      chk("t5_count", err_count, exp_cnt);
    end
    chk("t5_saturated", err_count, 15);

    // clear wins over a simultaneous errored handshake
    set_req(0, 8'hA5, 1'b1, 1'b0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    chk("t5_clr_in_resp", bus.rsp_valid, 1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("t5_clr_count", err_count, 0);
    chk("t5_clr_valid", bus.rsp_valid, 0);

    // reset in CHECK drops the transaction
    run_txn(2, 8'h5A, 1'b1, 1'b0, r_id, r_data, r_err);
    chk("t6_pre_count", err_count, 1);
    set_req(1, 8'hA5, 1'b1, 1'b0);
    bus.req_valid = 4'b0010;
    #1;
    chk("t6_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.rsp_valid, 0);
    chk("t6_rst_ready", bus.req_ready, 0);
    chk("t6_rst_count", err_count, 0);
    chk("t6_rst_id", bus.rsp_id, 0);
    chk("t6_rst_data", bus.rsp_data, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_stale", bus.rsp_valid, 0);
    end
    set_req(0, 8'h03, 1'b0, 1'b0);
    set_req(1, 8'h07, 1'b1, 1'b0);
    bus.req_valid = 4'b0011;
    #1;
    chk("t6_first_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    chk("t6_rsp_valid", bus.rsp_valid, 1);
    chk("t6_rsp_id", bus.rsp_id, 0);
    chk("t6_rsp_data", bus.rsp_data, 8'h03);
    chk("t6_rsp_error", bus.rsp_error, 0);
    tick();
    chk("t6_final_count", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
